// File: rtl/rtc_poll_seq.sv
// Command sequencer for the RTC parallel-bus interface: periodic time/date
// refresh into a shadow bank plus on-demand single register writes.
module rtc_poll_seq #(
   parameter int unsigned POLL_DIV = 1_000_000,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       poll_en,
   input  logic       wr_req,
   input  logic [7:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic [7:0] rtc_ready,
   input  logic [7:0] rtc_dato,
   output logic       writef,
   output logic [7:0] id_port,
   output logic [7:0] dpico,
   output logic [7:0] sec,
   output logic [7:0] min,
   output logic [7:0] hour,
   output logic [7:0] day,
   output logic [7:0] mon,
   output logic [7:0] year,
   output logic       busy,
   output logic       wr_pending,
   output logic       wr_ack,
   output logic       round_done,
   output logic       err
);

   localparam int unsigned PW = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 1;
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL_DIV - 1);
   localparam logic [TW-1:0] TMO_LIMIT   = TW'(TIMEOUT);
   localparam logic [2:0]    LAST_IDX    = 3'd6;

   typedef enum logic [2:0] {
      IDLE,
      SET_DIR,
      SET_DATA,
      SET_FUNC,
      WAIT_LOW,
      WAIT_HIGH,
      CAPTURE,
      GAP
   } state_t;

   state_t        state_q, state_d;
   logic          op_wr_q, op_wr_d;
   logic [2:0]    idx_q, idx_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [PW-1:0] poll_cnt_q, poll_cnt_d;
   logic          poll_flag_q, poll_flag_d;
   logic          wr_pending_q, wr_pending_d;
   logic [7:0]    wr_addr_q, wr_addr_d;
   logic [7:0]    wr_data_q, wr_data_d;
   logic          writef_q, writef_d;
   logic [7:0]    id_port_q, id_port_d;
   logic [7:0]    dpico_q, dpico_d;
   logic [7:0]    sec_q, sec_d, min_q, min_d, hour_q, hour_d;
   logic [7:0]    day_q, day_d, mon_q, mon_d, year_q, year_d;
   logic          busy_q, busy_d;
   logic          wr_ack_q, wr_ack_d;
   logic          round_done_q, round_done_d;
   logic          err_q, err_d;

   logic          poll_tick;
   logic          round_start;
   logic          load_en;
   logic          abort;
   logic [7:0]    rd_addr;

   always_comb begin
      state_d      = state_q;
      op_wr_d      = op_wr_q;
      idx_d        = idx_q;
      tmo_d        = tmo_q;
      poll_cnt_d   = poll_cnt_q;
      wr_pending_d = wr_pending_q;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      sec_d        = sec_q;
      min_d        = min_q;
      hour_d       = hour_q;
      day_d        = day_q;
      mon_d        = mon_q;
      year_d       = year_q;
      err_d        = err_q;
      wr_ack_d     = 1'b0;
      round_done_d = 1'b0;
      poll_tick    = 1'b0;
      round_start  = 1'b0;
      load_en      = 1'b0;
      abort        = 1'b0;

      if (poll_cnt_q == '0) begin
         poll_cnt_d = POLL_RELOAD;
         poll_tick  = 1'b1;
      end else begin
         poll_cnt_d = poll_cnt_q - 1'b1;
      end

      if (wr_req && !wr_pending_q) begin
         wr_pending_d = 1'b1;
         wr_addr_d    = wr_addr;
         wr_data_d    = wr_data;
      end

      case (state_q)
         IDLE: begin
            if (wr_pending_q) begin
               op_wr_d = 1'b1;
               state_d = SET_DIR;
            end else if (poll_en && poll_flag_q) begin
               op_wr_d     = 1'b0;
               idx_d       = '0;
               round_start = 1'b1;
               state_d     = SET_DIR;
            end
         end
         SET_DIR:  state_d = op_wr_q ? SET_DATA : SET_FUNC;
         SET_DATA: state_d = SET_FUNC;
         SET_FUNC: begin
            tmo_d   = TW'(1);
            state_d = WAIT_LOW;
         end
         WAIT_LOW: begin
            if (rtc_ready == 8'h00) begin
               state_d = WAIT_HIGH;
            end else if (tmo_q == TMO_LIMIT) begin
               abort = 1'b1;
            end
         end
         WAIT_HIGH: begin
            if (rtc_ready == 8'hFF) begin
               state_d = CAPTURE;
               if (op_wr_q) begin
                  wr_ack_d     = 1'b1;
                  wr_pending_d = 1'b0;
               end else begin
                  load_en = 1'b1;
               end
            end else if (tmo_q == TMO_LIMIT) begin
               abort = 1'b1;
            end
         end
         CAPTURE: begin
            state_d = GAP;
            if (!op_wr_q && idx_q == LAST_IDX) round_done_d = 1'b1;
         end
         GAP: begin
            if (!op_wr_q && idx_q != LAST_IDX) begin
               idx_d   = idx_q + 3'd1;
               state_d = SET_DIR;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Saturating so a late WAIT_LOW exit cannot wrap and stretch the timeout.
      if ((state_q == WAIT_LOW || state_q == WAIT_HIGH) && tmo_q != TMO_LIMIT) begin
         tmo_d = tmo_q + 1'b1;
      end

      if (abort) begin
         state_d = IDLE;
         err_d   = 1'b1;
         if (op_wr_q) wr_pending_d = 1'b0;
      end

      if (load_en) begin
         case (idx_q)
            3'd1: sec_d  = rtc_dato;
            3'd2: min_d  = rtc_dato;
            3'd3: hour_d = rtc_dato;
            3'd4: day_d  = rtc_dato;
            3'd5: mon_d  = rtc_dato;
            3'd6: year_d = rtc_dato;
            default: ;
         endcase
      end

      poll_flag_d = poll_en && (poll_tick || (poll_flag_q && !round_start));

      // Bus outputs follow the next state so they are valid for the whole state cycle.
      rd_addr   = (idx_d == 3'd0) ? 8'h00 : {5'b00100, idx_d};
      writef_d  = 1'b0;
      id_port_d = '0;
      dpico_d   = '0;
      case (state_d)
         SET_DIR: begin
            writef_d = 1'b1;
            dpico_d  = op_wr_d ? wr_addr_q : rd_addr;
         end
         SET_DATA: begin
            writef_d  = 1'b1;
            id_port_d = 8'h02;
            dpico_d   = wr_data_q;
         end
         SET_FUNC: begin
            writef_d  = 1'b1;
            id_port_d = 8'h01;
            dpico_d   = op_wr_d ? 8'h02 : 8'h01;
         end
         default: ;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         op_wr_q      <= 1'b0;
         idx_q        <= '0;
         tmo_q        <= '0;
         poll_cnt_q   <= POLL_RELOAD;
         poll_flag_q  <= 1'b0;
         wr_pending_q <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         writef_q     <= 1'b0;
         id_port_q    <= '0;
         dpico_q      <= '0;
         sec_q        <= '0;
         min_q        <= '0;
         hour_q       <= '0;
         day_q        <= '0;
         mon_q        <= '0;
         year_q       <= '0;
         busy_q       <= 1'b0;
         wr_ack_q     <= 1'b0;
         round_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_wr_q      <= op_wr_d;
         idx_q        <= idx_d;
         tmo_q        <= tmo_d;
         poll_cnt_q   <= poll_cnt_d;
         poll_flag_q  <= poll_flag_d;
         wr_pending_q <= wr_pending_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         writef_q     <= writef_d;
         id_port_q    <= id_port_d;
         dpico_q      <= dpico_d;
         sec_q        <= sec_d;
         min_q        <= min_d;
         hour_q       <= hour_d;
         day_q        <= day_d;
         mon_q        <= mon_d;
         year_q       <= year_d;
         busy_q       <= busy_d;
         wr_ack_q     <= wr_ack_d;
         round_done_q <= round_done_d;
         err_q        <= err_d;
      end
   end

   assign writef     = writef_q;
   assign id_port    = id_port_q;
   assign dpico      = dpico_q;
   assign sec        = sec_q;
   assign min        = min_q;
   assign hour       = hour_q;
   assign day        = day_q;
   assign mon        = mon_q;
   assign year       = year_q;
   assign busy       = busy_q;
   assign wr_pending = wr_pending_q;
   assign wr_ack     = wr_ack_q;
   assign round_done = round_done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_rtc_poll_seq.sv
// Directed bench for rtc_poll_seq with a behavioural RTC bus interface model.
module tb_rtc_poll_seq;

   localparam int unsigned POLL_DIV = 16;
   localparam int unsigned TIMEOUT  = 64;
   localparam int          LAT      = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic       poll_en;
   logic       wr_req;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic [7:0] rtc_ready = 8'hFF;
   logic [7:0] rtc_dato  = 8'h00;
   logic       writef;
   logic [7:0] id_port, dpico;
   logic [7:0] sec, min, hour, day, mon, year;
   logic       busy, wr_pending, wr_ack, round_done, err;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      int         cyc;
      logic [7:0] id;
      logic [7:0] d;
   } strobe_t;

   strobe_t    slog[$];
   strobe_t    s_new;
   int         rd_cnt    = 0;
   int         ack_cnt   = 0;
   int         idle_viol = 0;
   logic [7:0] mem [0:255];
   logic       m_init = 1'b0;
   logic       stuck  = 1'b0;
   logic       m_hang = 1'b0;
   logic       m_wr   = 1'b0;
   logic [7:0] m_addr = 8'h00;
   logic [7:0] m_data = 8'h00;
   int         m_cnt  = 0;

   rtc_poll_seq #(.POLL_DIV(POLL_DIV), .TIMEOUT(TIMEOUT)) dut (
      .clock(clock), .reset(reset), .poll_en(poll_en),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .rtc_ready(rtc_ready), .rtc_dato(rtc_dato),
      .writef(writef), .id_port(id_port), .dpico(dpico),
      .sec(sec), .min(min), .hour(hour), .day(day), .mon(mon), .year(year),
      .busy(busy), .wr_pending(wr_pending), .wr_ack(wr_ack),
      .round_done(round_done), .err(err)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Interface model and bus monitor: answers a function write after LAT cycles.
   always @(negedge clock) begin
      if (!m_init) begin
         for (int i = 0; i < 256; i++) mem[i] = 8'h00;
         mem[8'h21] = 8'h45; mem[8'h22] = 8'h30; mem[8'h23] = 8'h11;
         mem[8'h24] = 8'h07; mem[8'h25] = 8'h03; mem[8'h26] = 8'h16;
         m_init = 1'b1;
      end
      if (!reset) begin
         rtc_ready = 8'hFF;
         m_cnt     = 0;
         m_hang    = 1'b0;
      end else begin
         if (writef !== 1'b1 && (id_port !== 8'h00 || dpico !== 8'h00)) idle_viol++;
         if (round_done === 1'b1) rd_cnt++;
         if (wr_ack === 1'b1) ack_cnt++;
         if (m_hang && !stuck) begin
            m_hang    = 1'b0;
            rtc_ready = 8'hFF;
         end
         if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               rtc_ready = 8'hFF;
               if (!m_wr) rtc_dato = mem[m_addr];
            end
         end
         if (writef === 1'b1) begin
            s_new.cyc = cyc;
            s_new.id  = id_port;
            s_new.d   = dpico;
            slog.push_back(s_new);
            case (id_port)
               8'h00: m_addr = dpico;
               8'h02: m_data = dpico;
               8'h01: begin
                  m_wr = (dpico == 8'h02);
                  if (m_wr) mem[m_addr] = m_data;
                  rtc_ready = 8'h00;
                  if (stuck) m_hang = 1'b1;
                  else m_cnt = LAT;
               end
               default: ;
            endcase
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [15:0] round_strobe(input int k);
      logic [7:0] a;
      if (k % 2 == 1) return 16'h0101;
      a = (k == 0) ? 8'h00 : 8'(32'h20 + k / 2);
      return {8'h00, a};
   endfunction

   task automatic test_reset();
      int n;
      reset = 1'b0;
      poll_en = 1'b1;
      repeat (3) tick();
      checks++;
      if ({writef, id_port, dpico, busy, wr_pending, wr_ack, round_done, err} !== 22'h0) begin
         $display("FAIL reset_ctrl: got %h expected 0",
                  {writef, id_port, dpico, busy, wr_pending, wr_ack, round_done, err});
         errors++;
      end
      checks++;
      if ({sec, min, hour, day, mon, year} !== 48'h0) begin
         $display("FAIL reset_shadow: got %h expected 0", {sec, min, hour, day, mon, year});
         errors++;
      end
      reset = 1'b1;
      n = 0;
      while (writef !== 1'b1 && n < 40) begin tick(); n++; end
      checks++;
      if (n != 17) begin
         $display("FAIL first_round_latency: got %0d cycles expected 17", n);
         errors++;
      end
      reset = 1'b0;
      poll_en = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      repeat (3) tick();
      checks++;
      if ({busy, writef} !== 2'b00) begin
         $display("FAIL reset_idle: got busy,writef=%b expected 00", {busy, writef});
         errors++;
      end
   endtask

   task automatic test_poll_round(input logic [7:0] es, em, eh, ed, emo, ey);
      int base, rd0, n;
      logic [15:0] exp_s;
      base = slog.size();
      rd0  = rd_cnt;
      poll_en = 1'b1;
      n = 0;
      while (round_done !== 1'b1 && n < 400) begin tick(); n++; end
      poll_en = 1'b0;
      checks++;
      if (round_done !== 1'b1) begin
         $display("FAIL round_done_wait: got %b expected 1 within 400 cycles", round_done);
         errors++;
      end
      checks++;
      if ({sec, min, hour, day, mon, year} !== {es, em, eh, ed, emo, ey}) begin
         $display("FAIL round_shadow: got %h expected %h",
                  {sec, min, hour, day, mon, year}, {es, em, eh, ed, emo, ey});
         errors++;
      end
      repeat (5) tick();
      checks++;
      if (slog.size() - base != 14) begin
         $display("FAIL round_strobe_count: got %0d expected 14", slog.size() - base);
         errors++;
      end
      for (int k = 0; k < 14; k++) begin
         if (base + k < slog.size()) begin
            exp_s = round_strobe(k);
            checks++;
            if ({slog[base+k].id, slog[base+k].d} !== exp_s) begin
               $display("FAIL round_strobe[%0d]: got %h expected %h", k,
                        {slog[base+k].id, slog[base+k].d}, exp_s);
               errors++;
            end
            if (k % 2 == 1) begin
               checks++;
               if (slog[base+k].cyc != slog[base+k-1].cyc + 1) begin
                  $display("FAIL round_strobe_gap[%0d]: got %0d cycles expected 1", k,
                           slog[base+k].cyc - slog[base+k-1].cyc);
                  errors++;
               end
            end
         end
      end
      checks++;
      if (rd_cnt - rd0 != 1) begin
         $display("FAIL round_done_pulses: got %0d expected 1", rd_cnt - rd0);
         errors++;
      end
   endtask

   task automatic test_write();
      int base, ack0, n;
      logic [47:0] shadow0;
      logic [47:0] exp_w;
      base = slog.size();
      ack0 = ack_cnt;
      shadow0 = {sec, min, hour, day, mon, year};
      wr_addr = 8'h22; wr_data = 8'h15; wr_req = 1'b1;
      tick();
      wr_req = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
      checks++;
      if (wr_pending !== 1'b1) begin
         $display("FAIL write_pending: got %b expected 1", wr_pending);
         errors++;
      end
      n = 0;
      while (wr_ack !== 1'b1 && n < 60) begin tick(); n++; end
      checks++;
      if (n != 8) begin
         $display("FAIL write_ack_latency: got %0d cycles expected 8", n);
         errors++;
      end
      checks++;
      if (wr_pending !== 1'b0) begin
         $display("FAIL write_pending_clear: got %b expected 0", wr_pending);
         errors++;
      end
      repeat (3) tick();
      checks++;
      if (slog.size() - base != 3) begin
         $display("FAIL write_strobe_count: got %0d expected 3", slog.size() - base);
         errors++;
      end else begin
         exp_w = {16'h0022, 16'h0215, 16'h0102};
         checks++;
         if ({slog[base].id, slog[base].d, slog[base+1].id, slog[base+1].d,
              slog[base+2].id, slog[base+2].d} !== exp_w) begin
            $display("FAIL write_strobes: got %h%h%h%h%h%h expected %h",
                     slog[base].id, slog[base].d, slog[base+1].id, slog[base+1].d,
                     slog[base+2].id, slog[base+2].d, exp_w);
            errors++;
         end
         checks++;
         if (slog[base+2].cyc - slog[base].cyc != 2) begin
            $display("FAIL write_consecutive: got span %0d expected 2",
                     slog[base+2].cyc - slog[base].cyc);
            errors++;
         end
      end
      checks++;
      if (ack_cnt - ack0 != 1) begin
         $display("FAIL write_ack_pulses: got %0d expected 1", ack_cnt - ack0);
         errors++;
      end
      checks++;
      if ({sec, min, hour, day, mon, year} !== 48'h453011070316 ||
          {sec, min, hour, day, mon, year} !== shadow0) begin
         $display("FAIL write_shadow: got %h expected 453011070316", {sec, min, hour, day, mon, year});
         errors++;
      end
   endtask

   task automatic test_write_during_round();
      int base, ack0, rd0, n;
      logic [15:0] exp_s;
      base = slog.size();
      ack0 = ack_cnt;
      rd0  = rd_cnt;
      poll_en = 1'b1;
      n = 0;
      while (!(writef === 1'b1 && id_port === 8'h00 && dpico === 8'h22) && n < 400) begin
         tick(); n++;
      end
      checks++;
      if (n >= 400) begin
         $display("FAIL wdr_third_read: got no (00,22) strobe expected one within 400 cycles");
         errors++;
      end
      wr_addr = 8'h24; wr_data = 8'h09; wr_req = 1'b1;
      tick();
      wr_req = 1'b0;
      tick();
      wr_addr = 8'h25; wr_data = 8'h77; wr_req = 1'b1;
      tick();
      wr_req = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
      checks++;
      if ({wr_pending, busy} !== 2'b11) begin
         $display("FAIL wdr_pending: got pending,busy=%b expected 11", {wr_pending, busy});
         errors++;
      end
      n = 0;
      while (round_done !== 1'b1 && n < 400) begin tick(); n++; end
      poll_en = 1'b0;
      checks++;
      if ({sec, min, hour, day, mon, year} !== 48'h451511070316) begin
         $display("FAIL wdr_shadow: got %h expected 451511070316", {sec, min, hour, day, mon, year});
         errors++;
      end
      n = 0;
      while (wr_ack !== 1'b1 && n < 100) begin tick(); n++; end
      checks++;
      if (wr_ack !== 1'b1) begin
         $display("FAIL wdr_ack_wait: got %b expected 1 within 100 cycles", wr_ack);
         errors++;
      end
      repeat (3) tick();
      checks++;
      if (slog.size() - base != 17) begin
         $display("FAIL wdr_strobe_count: got %0d expected 17", slog.size() - base);
         errors++;
      end
      for (int k = 0; k < 17; k++) begin
         if (base + k < slog.size()) begin
            if (k < 14) exp_s = round_strobe(k);
            else if (k == 14) exp_s = 16'h0024;
            else if (k == 15) exp_s = 16'h0209;
            else exp_s = 16'h0102;
            checks++;
            if ({slog[base+k].id, slog[base+k].d} !== exp_s) begin
               $display("FAIL wdr_strobe[%0d]: got %h expected %h", k,
                        {slog[base+k].id, slog[base+k].d}, exp_s);
               errors++;
            end
         end
      end
      checks++;
      if ({ack_cnt - ack0, rd_cnt - rd0} != {32'd1, 32'd1}) begin
         $display("FAIL wdr_pulses: got acks=%0d rounds=%0d expected 1 and 1",
                  ack_cnt - ack0, rd_cnt - rd0);
         errors++;
      end
   endtask

   task automatic test_poll_disabled();
      int base, ack0;
      base = slog.size();
      ack0 = ack_cnt;
      poll_en = 1'b0;
      repeat (16) tick();
      wr_addr = 8'h21; wr_data = 8'h59; wr_req = 1'b1;
      tick();
      wr_req = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
      repeat (32) tick();
      checks++;
      if (slog.size() - base != 3) begin
         $display("FAIL nopoll_strobe_count: got %0d expected 3", slog.size() - base);
         errors++;
      end else begin
         checks++;
         if ({slog[base].id, slog[base].d, slog[base+1].id, slog[base+1].d,
              slog[base+2].id, slog[base+2].d} !== 48'h0021_0259_0102) begin
            $display("FAIL nopoll_strobes: got %h%h%h%h%h%h expected 002102590102",
                     slog[base].id, slog[base].d, slog[base+1].id, slog[base+1].d,
                     slog[base+2].id, slog[base+2].d);
            errors++;
         end
      end
      checks++;
      if (ack_cnt - ack0 != 1) begin
         $display("FAIL nopoll_ack: got %0d expected 1", ack_cnt - ack0);
         errors++;
      end
   endtask

   task automatic test_timeout();
      int rd0, n;
      rd0 = rd_cnt;
      stuck = 1'b1;
      poll_en = 1'b1;
      n = 0;
      while (!(writef === 1'b1 && id_port === 8'h01) && n < 100) begin tick(); n++; end
      checks++;
      if (n >= 100) begin
         $display("FAIL tmo_func_wait: got no function strobe expected one within 100 cycles");
         errors++;
      end
      repeat (TIMEOUT) tick();
      checks++;
      if ({err, busy} !== 2'b01) begin
         $display("FAIL tmo_before: got err,busy=%b expected 01", {err, busy});
         errors++;
      end
      tick();
      poll_en = 1'b0;
      checks++;
      if ({err, busy} !== 2'b10) begin
         $display("FAIL tmo_abort: got err,busy=%b expected 10", {err, busy});
         errors++;
      end
      stuck = 1'b0;
      repeat (3) tick();
      checks++;
      if ({err, busy, wr_pending} !== 3'b100) begin
         $display("FAIL tmo_sticky: got err,busy,pending=%b expected 100", {err, busy, wr_pending});
         errors++;
      end
      checks++;
      if (rd_cnt - rd0 != 0) begin
         $display("FAIL tmo_round_done: got %0d pulses expected 0", rd_cnt - rd0);
         errors++;
      end
      checks++;
      if ({sec, min, hour, day, mon, year} !== 48'h591511090316) begin
         $display("FAIL tmo_shadow: got %h expected 591511090316", {sec, min, hour, day, mon, year});
         errors++;
      end
   endtask

   task automatic test_reset_mid_round();
      int n, base;
      poll_en = 1'b1;
      n = 0;
      while (!(writef === 1'b1 && id_port === 8'h00 && dpico === 8'h23) && n < 400) begin
         tick(); n++;
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({writef, id_port, dpico, busy, wr_pending, wr_ack, round_done, err} !== 22'h0) begin
         $display("FAIL midreset_ctrl: got %h expected 0",
                  {writef, id_port, dpico, busy, wr_pending, wr_ack, round_done, err});
         errors++;
      end
      checks++;
      if ({sec, min, hour, day, mon, year} !== 48'h0) begin
         $display("FAIL midreset_shadow: got %h expected 0", {sec, min, hour, day, mon, year});
         errors++;
      end
      poll_en = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      base = slog.size();
      repeat (5) tick();
      checks++;
      if ({busy, writef, wr_pending} !== 3'b000 || slog.size() != base) begin
         $display("FAIL midreset_idle: got busy,writef,pending=%b strobes=%0d expected 000 and 0",
                  {busy, writef, wr_pending}, slog.size() - base);
         errors++;
      end
   endtask

   task automatic test_idle_bus();
      checks++;
      if (idle_viol != 0) begin
         $display("FAIL idle_bus_zero: got %0d nonzero idle cycles expected 0", idle_viol);
         errors++;
      end
   endtask

   initial begin
      reset   = 1'b0;
      poll_en = 1'b0;
      wr_req  = 1'b0;
      wr_addr = 8'h00;
      wr_data = 8'h00;
      test_reset();
      test_poll_round(8'h45, 8'h30, 8'h11, 8'h07, 8'h03, 8'h16);
      test_write();
      test_write_during_round();
      test_poll_disabled();
      test_poll_round(8'h59, 8'h15, 8'h11, 8'h09, 8'h03, 8'h16);
      test_timeout();
      test_reset_mid_round();
      test_idle_bus();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rtc_poll_seq.md
# rtc_poll_seq

Command sequencer placed directly upstream of the RTC parallel-bus interface. It drives that interface's port-write inputs (`writef`/`id_port`/`dpico`) in place of the PicoBlaze. It watches the `ready` handshake and reads back `datoext`. It periodically refreshes a shadow bank of time/date registers for the display logic, and it inserts single register writes on request.

## Interface
Parameters:
- `POLL_DIV`, 1_000_000: clock cycles between automatic refresh rounds (≥ 16).
- `TIMEOUT`, 255: maximum cycles from the function write to `ready`==8'hFF before abort (≥ 64).

Ports:
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low; all state cleared while low.
- `poll_en` in 1: enables automatic refresh rounds.
- `wr_req` in 1: one-cycle pulse requesting an RTC register write.
- `wr_addr` in 8: RTC register address for the write, sampled with `wr_req`.
- `wr_data` in 8: data for the write, sampled with `wr_req`.
- `rtc_ready` in 8: interface `ready` (8'h00 busy, 8'hFF done).
- `rtc_dato` in 8: interface `datoext`.
- `writef` out 1: port-write strobe to the interface.
- `id_port` out 8: port id (00 address, 01 function, 02 write data).
- `dpico` out 8: port data.
- `sec`, `min`, `hour`, `day`, `mon`, `year` out 8 each: shadow registers.
- `busy` out 1: a transaction is in progress.
- `wr_pending` out 1: a write has been accepted and has not yet completed.
- `wr_ack` out 1: one-cycle pulse when a write completes.
- `round_done` out 1: one-cycle pulse after the last capture of a round.
- `err` out 1: sticky timeout flag.

## Operation
- Reset values: `writef`=0, `id_port`=00, `dpico`=00, all shadow registers=00, `busy`/`wr_pending`/`wr_ack`/`round_done`/`err`=0, poll timer=`POLL_DIV`-1, poll flag=0, state IDLE.
- Poll timer: free-running down-counter. At 0 it reloads and sets the poll flag.
  - The poll flag is cleared when a round starts.
  - The poll flag is also cleared when `poll_en`=0.
- Write request:
  - `wr_req` is accepted only when `wr_pending`=0. Acceptance latches `wr_addr`/`wr_data` and sets `wr_pending`.
  - A `wr_req` arriving while `wr_pending`=1 is dropped.
- Arbitration in IDLE: a pending write has priority over a poll round.
  - A write arriving mid-round is serviced after the current round completes.
- Round sequence, 7 reads in fixed order:
  - 0x00 (control; primes the interface's 12/24 h format; nothing captured).
  - 0x21→`sec`, 0x22→`min`, 0x23→`hour`, 0x24→`day`, 0x25→`mon`, 0x26→`year`.
- States: IDLE → SET_DIR → [SET_DATA, writes only] → SET_FUNC → WAIT_LOW → WAIT_HIGH → CAPTURE → GAP → (next read: SET_DIR | done: IDLE).
  - SET_DIR: `writef`=1, `id_port`=00, `dpico`=address.
  - SET_DATA: `writef`=1, `id_port`=02, `dpico`=write data.
  - SET_FUNC: `writef`=1, `id_port`=01, `dpico`=01 for a read or 02 for a write.
  - WAIT_LOW: waits for `rtc_ready`==8'h00. This ignores the stale 8'hFF left from the previous transaction.
  - WAIT_HIGH: waits for `rtc_ready`==8'hFF.
  - CAPTURE: loads `rtc_dato` into the addressed shadow register (reads of 0x21–0x26 only).
  - GAP: one idle cycle.
- Write completion: `wr_ack` pulses in the CAPTURE-slot cycle, `wr_pending` clears, then IDLE.
- Timeout: a counter starts at SET_FUNC. If it reaches `TIMEOUT` in WAIT_LOW or WAIT_HIGH:
  - `err` is set; it stays set until reset.
  - The round is abandoned, so `round_done` does not pulse and shadow registers keep their old values.
  - For a write, `wr_pending` clears with no `wr_ack`.
  - The state goes to IDLE.
- Reset mid-transaction: outputs return to reset values immediately. The downstream interface is reset separately.

## Timing
- `writef` is high for exactly one cycle per port write.
  - Read: 2 consecutive strobe cycles (address, function).
  - Write: 3 consecutive strobe cycles (address, data, function).
- `id_port`/`dpico` return to 00 in every cycle where `writef`=0.
- The shadow register updates on the edge after `rtc_ready`==8'hFF is sampled in WAIT_HIGH.
- `round_done` is asserted the cycle after the `year` update.
- `busy`=1 from SET_DIR through GAP inclusive.
- Read latency, not counting interface time: 2 strobes + WAIT_LOW + WAIT_HIGH + CAPTURE + GAP. With the interface's 41-cycle operation, one read takes ≈ 46 cycles and one round ≈ 320 cycles.
- A poll flag raised during a round is held and starts a new round after IDLE. At most one round is queued.

## Test plan
- Reset: hold `reset` low mid-round. All outputs are 0 asynchronously, and the state is IDLE after release.
- Poll round:
  - Setup: `POLL_DIV`=16, `poll_en`=1, and a behavioural interface model returning 0x45, 0x30, 0x11, 0x07, 0x03, 0x16 for 0x21..0x26.
  - Required: a strobe sequence of 7 reads in order; shadow registers equal those values; exactly one `round_done` pulse.
- Write:
  - Stimulus: `wr_req` with addr 0x22, data 0x15, while idle.
  - Required: strobes (00,0x22),(02,0x15),(01,02) on 3 consecutive cycles, then one `wr_ack` pulse; shadow registers unchanged.
- Write during round:
  - Stimulus: `wr_req` at the third read, plus a second `wr_req` while pending.
  - Required: the round completes first, then only the first write is issued, with a single `wr_ack`.
- Timeout:
  - Stimulus: the model holds `rtc_ready` at 8'h00 forever.
  - Required: after `TIMEOUT` cycles `err`=1 and the state is IDLE, with no `round_done` and shadow registers unchanged.
- `poll_en`=0: no strobes for 3×`POLL_DIV` cycles, while writes are still serviced.
